// File: rtl/pb_seq_pkg.sv
// Shared definitions for the pushbutton irq sequencer: PIO register map,
// sequencer states and a small helper for building PIO write words.
package pb_seq_pkg;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  localparam int EVT_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_MASK = 3'd1,
    RD_CAP  = 3'd2,
    CLR     = 3'd3,
    PUSH    = 3'd4,
    HOLD    = 3'd5,
    FLUSH   = 3'd6
  } state_e;

  function automatic logic [31:0] pio_word(input logic [EVT_W-1:0] v);
    return {{(32 - EVT_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/pb_event_fifo.sv
// Synchronous event FIFO. Pointers carry one extra wrap bit so full and empty
// are distinguishable; a push into a full FIFO is accepted when a pop frees the slot.
module pb_event_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_pop;
  logic         do_push;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pushbutton_irq_sequencer.sv
// Avalon-MM master servicing the pushbutton PIO: programs irq_mask, reads and
// clears edge_capture on irq, debounces with a hold-off plus flush, queues events.
module pushbutton_irq_sequencer
  import pb_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int HOLDOFF    = 16,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pio_irq,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  input  logic [3:0]       cfg_mask,
  input  logic             cfg_load,
  output logic             evt_valid,
  output logic [3:0]       evt_data,
  input  logic             evt_ready,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] spurious_cnt,
  output logic             busy,
  output logic [2:0]       dbg_state_o
);

  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = (HOLDOFF > 0) ? HW'(HOLDOFF - 1) : '0;

  state_e           state_q, state_d;
  logic [3:0]       mask_q;
  logic             cfg_pend_q;
  logic [3:0]       cap_q;
  logic [HW-1:0]    hold_cnt_q;
  logic             overflow_q;
  logic [CNT_W-1:0] spur_q;

  logic cfg_clr;
  logic cap_en;
  logic fifo_push;
  logic ovf_set;
  logic spur_inc;
  logic hold_load;
  logic hold_dec;
  logic fifo_full;
  logic fifo_empty;

  logic unused_readdata;
  assign unused_readdata = ^avm_readdata[31:4];

  always_comb begin
    state_d        = state_q;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = PIO_ADDR_DATA;
    avm_writedata  = '0;
    cfg_clr        = 1'b0;
    cap_en         = 1'b0;
    fifo_push      = 1'b0;
    ovf_set        = 1'b0;
    spur_inc       = 1'b0;
    hold_load      = 1'b0;
    hold_dec       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_pend_q) begin
          state_d = WR_MASK;
        end else if (pio_irq) begin
          state_d = RD_CAP;
        end
      end
      WR_MASK: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = PIO_ADDR_MASK;
        avm_writedata  = pio_word(mask_q);
        cfg_clr        = 1'b1;
        state_d        = IDLE;
      end
      RD_CAP: begin
        avm_chipselect = 1'b1;
        avm_address    = PIO_ADDR_EDGE;
        state_d        = CLR;
      end
      CLR: begin
        // readdata for the RD_CAP address is valid in this cycle
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = PIO_ADDR_EDGE;
        cap_en         = 1'b1;
        state_d        = PUSH;
      end
      PUSH: begin
        if (cap_q == 4'h0) begin
          spur_inc = 1'b1;
          state_d  = IDLE;
        end else begin
          fifo_push = 1'b1;
          ovf_set   = fifo_full && !evt_ready;
          if (HOLDOFF == 0) begin
            state_d = IDLE;
          end else begin
            hold_load = 1'b1;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (hold_cnt_q == '0) begin
          state_d = FLUSH;
        end else begin
          hold_dec = 1'b1;
        end
      end
      FLUSH: begin
        // drop any bounce edges captured during the hold-off
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = PIO_ADDR_EDGE;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mask_q     <= 4'h0;
      cfg_pend_q <= 1'b1;
      cap_q      <= 4'h0;
      hold_cnt_q <= '0;
      overflow_q <= 1'b0;
      spur_q     <= '0;
    end else begin
      state_q <= state_d;
      if (cfg_load) begin
        mask_q <= cfg_mask;
      end
      // a load landing in the WR_MASK cycle must still be written out
      if (cfg_load) begin
        cfg_pend_q <= 1'b1;
      end else if (cfg_clr) begin
        cfg_pend_q <= 1'b0;
      end
      if (cap_en) begin
        cap_q <= avm_readdata[3:0] & mask_q;
      end
      if (hold_load) begin
        hold_cnt_q <= HOLD_LOAD;
      end else if (hold_dec) begin
        hold_cnt_q <= hold_cnt_q - 1'b1;
      end
      if (ovf_set) begin
        overflow_q <= 1'b1;
      end else if (ovf_clr) begin
        overflow_q <= 1'b0;
      end
      if (spur_inc && (spur_q != {CNT_W{1'b1}})) begin
        spur_q <= spur_q + 1'b1;
      end
    end
  end

  pb_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (fifo_push),
    .wdata_i (cap_q),
    .pop_i   (evt_ready),
    .rdata_o (evt_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign evt_valid    = !fifo_empty;
  assign overflow     = overflow_q;
  assign spurious_cnt = spur_q;
  assign busy         = (state_q != IDLE);
  assign dbg_state_o  = state_q;

endmodule
